// File: rtl/multi_crop_stream_pkg.sv
// crop_pkg: shared types and coordinate helpers for multi_crop_stream.
// Coordinates are carried internally at CW bits regardless of the port widths.
package crop_pkg;
    localparam int CW = 16;
    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
    typedef logic [15:0] pixel_t;
    typedef struct packed {
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } coord_t;
    function automatic logic over_limit(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        return v > lim;
    endfunction
    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/multi_crop_stream_fifo.sv
// crop_chan_fifo: per-channel synchronous FIFO; accepts a push while full if a pop
// happens in the same cycle, and presents the head entry from registers.
module crop_chan_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp, r_rp;
    logic         w_empty, w_full, w_pop, w_push;

    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign o_ready = !w_full || w_pop;
    assign w_push  = i_push && o_ready;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/multi_crop_stream.sv
// multi_crop_stream: one-pass extraction of NUM_CROPS windows from a raster frame.
// Optional CROP_CLAMP_EN clamps out-of-range crop origins instead of muting the channel.
module multi_crop_stream
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10,
    parameter int NUM_CROPS        = 2,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                                     ap_clk,
    input  logic                                     ap_rst_n,
    input  logic                                     ap_start,
    output logic                                     ap_done,
    output logic                                     ap_ready,
    output logic                                     ap_idle,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] crop_coord_TDATA,
    input  logic                                     crop_coord_TVALID,
    output logic                                     crop_coord_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0]               crop_input_TDATA,
    input  logic                                     crop_input_TVALID,
    output logic                                     crop_input_TREADY,
    output logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0]     crop_out_TDATA,
    output logic [NUM_CROPS-1:0]                     crop_out_TVALID,
    output logic [NUM_CROPS-1:0]                     crop_out_TLAST,
    input  logic [NUM_CROPS-1:0]                     crop_out_TREADY,
    output logic [NUM_CROPS-1:0]                     crop_err
);
    localparam int LW = $clog2(NUM_CROPS + 1);
    localparam int W  = PIXEL_BIT_WIDTH;
    localparam logic [CW-1:0] LIM_Y = CW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0] LIM_X = CW'(IN_COLS - OUT_COLS);

    state_t               r_state;
    logic                 r_idle, r_done, r_cready;
    logic [LW-1:0]        r_ld;
    logic [CW-1:0]        r_row, r_col;
    coord_t               r_crd [NUM_CROPS];
    logic [NUM_CROPS-1:0] r_err;
    logic [NUM_CROPS-1:0] w_hit, w_last, w_fready;
    logic [CW-1:0]        w_y, w_x;
    logic                 w_accept, w_end;

    assign w_y = CW'(crop_coord_TDATA[IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1 -: IMG_ROW_BITWIDTH]);
    assign w_x = CW'(crop_coord_TDATA[IMG_COL_BITWIDTH-1:0]);
    // Only channels that want the current pixel may hold the input back.
    assign crop_input_TREADY = (r_state == STREAM) && &(~w_hit | w_fready);
    assign w_accept = crop_input_TVALID && crop_input_TREADY;
    assign w_end    = (r_row == CW'(IN_ROWS - 1)) && (r_col == CW'(IN_COLS - 1));
    assign crop_coord_TREADY = r_cready;
    assign ap_done  = r_done;
    assign ap_ready = r_done;
    assign ap_idle  = r_idle;
    assign crop_err = r_err;

    for (genvar k = 0; k < NUM_CROPS; k++) begin : g_ch
        logic [CW:0]  w_r, w_c, w_y0, w_x0, w_ye, w_xe;
        logic [W:0]   w_fdata;
        logic         w_en;
        assign w_r  = {1'b0, r_row};
        assign w_c  = {1'b0, r_col};
        assign w_y0 = {1'b0, r_crd[k].row};
        assign w_x0 = {1'b0, r_crd[k].col};
        assign w_ye = w_y0 + (CW+1)'(OUT_ROWS - 1);
        assign w_xe = w_x0 + (CW+1)'(OUT_COLS - 1);
`ifdef CROP_CLAMP_EN
        assign w_en = 1'b1;
`else
        assign w_en = !r_err[k];
`endif
        assign w_hit[k]  = w_en && (w_r >= w_y0) && (w_r <= w_ye) && (w_c >= w_x0) && (w_c <= w_xe);
        assign w_last[k] = (w_r == w_ye) && (w_c == w_xe);
        crop_chan_fifo #(.W(W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
            .i_clk   (ap_clk),
            .i_rst_n (ap_rst_n),
            .i_push  (w_accept && w_hit[k]),
            .i_data  ({w_last[k], crop_input_TDATA}),
            .o_ready (w_fready[k]),
            .o_valid (crop_out_TVALID[k]),
            .o_data  (w_fdata),
            .i_ready (crop_out_TREADY[k])
        );
        assign crop_out_TDATA[k*W +: W] = w_fdata[W-1:0];
        assign crop_out_TLAST[k] = crop_out_TVALID[k] && w_fdata[W];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state  <= IDLE;
            r_idle   <= 1'b1;
            r_done   <= 1'b0;
            r_cready <= 1'b0;
            r_ld     <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_err    <= '0;
            for (int k = 0; k < NUM_CROPS; k++) r_crd[k] <= '0;
        end else begin
            case (r_state)
                IDLE: if (ap_start) begin
                    r_state  <= LOAD;
                    r_idle   <= 1'b0;
                    r_cready <= 1'b1;
                    r_ld     <= '0;
                    r_err    <= '0;
                end
                LOAD: if (crop_coord_TVALID) begin
                    for (int k = 0; k < NUM_CROPS; k++) begin
                        if (r_ld == LW'(k)) begin
`ifdef CROP_CLAMP_EN
                            r_crd[k] <= '{row: clamp(w_y, LIM_Y), col: clamp(w_x, LIM_X)};
`else
                            r_crd[k] <= '{row: w_y, col: w_x};
`endif
                            r_err[k] <= over_limit(w_y, LIM_Y) || over_limit(w_x, LIM_X);
                        end
                    end
                    r_ld <= r_ld + LW'(1);
                    if (r_ld == LW'(NUM_CROPS - 1)) begin
                        r_cready <= 1'b0;
                        r_state  <= STREAM;
                        r_row    <= '0;
                        r_col    <= '0;
                    end
                end
                STREAM: if (w_accept) begin
                    if (w_end) r_state <= DRAIN;
                    else if (r_col == CW'(IN_COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + CW'(1);
                    end else r_col <= r_col + CW'(1);
                end
                // The final pixel's push lands on the same edge that enters DRAIN.
                DRAIN: if (~|crop_out_TVALID) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_idle  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
